// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump reader.
// - state_t       : FSM state encoding (HDR/CSUM are only reachable when
//                   REG_DUMP_FRAME_EN is defined).
// - FRAME_HEADER  : first byte of a framed dump.
// - BYTES_PER_REG : bytes per register word at the default width.
// - BYTE_CNT_W    : byte counter width at the default width.
// - byte_cnt_w()  : counter width for an arbitrary byte count (minimum 1).
package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE, LATCH, SEND, NEXT, DONE, HDR, CSUM
  } state_t;

  localparam logic [7:0] FRAME_HEADER   = 8'hA5;
  localparam int         DEF_DATA_WIDTH = 32;
  localparam int         BYTES_PER_REG  = DEF_DATA_WIDTH / 8;

  function automatic int byte_cnt_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int BYTE_CNT_W = byte_cnt_w(BYTES_PER_REG);

endpackage

// File: rtl/reg_dump_reader_word_byte_serializer.sv
// Word-to-byte serializer: loads a DATA_WIDTH word and presents it MSB byte
// first on a valid/ready byte interface.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   load           : capture word (has priority over an in-flight transfer)
//   load_byte      : the load carries a single byte in the top byte of word
//   word           : word to serialize
//   tx_data/valid  : byte output, held stable while stalled
//   tx_ready       : downstream accepts the byte this cycle
//   last           : the byte currently presented is the final one
//   xfer           : a byte transfers this cycle
module word_byte_serializer
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  load_byte,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  last,
  output logic                  xfer
);

  localparam int BPR = DATA_WIDTH / 8;
  localparam int CW  = byte_cnt_w(BPR);
  localparam logic [CW-1:0] LAST_IDX = CW'(BPR - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         byte_cnt;
  logic                  valid;

  // The presented byte is always the top byte of the shift register, so it
  // cannot change while stalled: the register only moves on a transfer.
  assign tx_data  = shreg[DATA_WIDTH-1 -: 8];
  assign tx_valid = valid;
  assign last     = (byte_cnt == LAST_IDX);
  assign xfer     = valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      // A single-byte load starts at the last index so one transfer ends it.
      byte_cnt <= load_byte ? LAST_IDX : '0;
      valid    <= 1'b1;
    end else if (xfer) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        shreg    <= shreg << 8;
        byte_cnt <= byte_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Register dump reader: on start, walks register addresses 0..NUM_REGS-1 on
// the register file debug read port and streams every word MSB byte first
// to the debug UART transmitter.
// Build option: define REG_DUMP_FRAME_EN to wrap the dump in a frame
// (header byte 8'hA5 first, XOR of all data bytes last).
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   start      : dump request, only looked at in IDLE
//   dbg_addr   : register address to the debug read port
//   dbg_data   : combinational read data for dbg_addr
//   tx_data    : byte to the transmitter
//   tx_valid   : tx_data is valid
//   tx_ready   : transmitter accepts the byte this cycle
//   busy       : dump in progress
//   done       : one-cycle pulse at dump completion
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state, state_nxt;
  logic                  ser_load, ser_load_byte;
  logic [DATA_WIDTH-1:0] ser_word;
  logic                  ser_last, ser_xfer;

`ifdef REG_DUMP_FRAME_EN
  logic [7:0] csum;
`endif

  word_byte_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_byte (ser_load_byte),
    .word      (ser_word),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .last      (ser_last),
    .xfer      (ser_xfer)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Header and checksum bytes are loaded on the edge that enters HDR/CSUM,
  // so the byte is already valid during the first cycle of those states.
  always_comb begin
    state_nxt     = state;
    ser_load      = 1'b0;
    ser_load_byte = 1'b0;
    ser_word      = dbg_data;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef REG_DUMP_FRAME_EN
          state_nxt     = HDR;
          ser_load      = 1'b1;
          ser_load_byte = 1'b1;
          ser_word      = DATA_WIDTH'(FRAME_HEADER) << (DATA_WIDTH - 8);
`else
          state_nxt = LATCH;
`endif
        end
      end
      LATCH: begin
        ser_load  = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (ser_xfer && ser_last) state_nxt = NEXT;
      end
      NEXT: begin
        if (dbg_addr == LAST_ADDR) begin
`ifdef REG_DUMP_FRAME_EN
          state_nxt     = CSUM;
          ser_load      = 1'b1;
          ser_load_byte = 1'b1;
          ser_word      = DATA_WIDTH'(csum) << (DATA_WIDTH - 8);
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = LATCH;
        end
      end
      DONE: state_nxt = IDLE;
`ifdef REG_DUMP_FRAME_EN
      HDR:  if (ser_xfer && ser_last) state_nxt = LATCH;
      CSUM: if (ser_xfer && ser_last) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Address sequencing and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbg_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef REG_DUMP_FRAME_EN
      csum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dbg_addr <= '0;
            busy     <= 1'b1;
`ifdef REG_DUMP_FRAME_EN
            csum     <= '0;
`endif
          end
        end
        NEXT: begin
          // Stops at the last address; never wraps within a dump.
          if (dbg_addr != LAST_ADDR) dbg_addr <= dbg_addr + ADDR_WIDTH'(1);
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          dbg_addr <= '0;
        end
        default: ;
      endcase
`ifdef REG_DUMP_FRAME_EN
      // Only data bytes feed the checksum; header and checksum go out in
      // HDR/CSUM, never in SEND.
      if (state == SEND && ser_xfer) csum <= csum ^ tx_data;
`endif
    end
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug-side reader for the CPU register file: on request, walks register addresses 0..NUM_REGS-1 through a dedicated debug read port and captures each 32-bit word.
- Streams each word as bytes over a valid/ready byte interface to the debug UART transmitter.
- Sits between the register file's debug read port and the debug UART TX in the debug unit.

Parameters:
- NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1.
- ADDR_WIDTH, 5, width of dbg_addr; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- DATA_WIDTH, 32, register width; must be a multiple of 8.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  dump request; sampled only in IDLE.
- dbg_addr  output  ADDR_WIDTH  register address driven to the register file debug read port.
- dbg_data  input  DATA_WIDTH  combinational read data for dbg_addr.
- tx_data  output  8  byte to the transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte this cycle.
- busy  output  1  high from the cycle after start is accepted until the cycle after DONE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (reset==0 at a clk edge) values: state=IDLE, dbg_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, shift register=0, byte counter=0. Reset mid-dump aborts immediately; tx_valid drops on the same edge and no further bytes are sent.
- States: IDLE, LATCH, SEND, NEXT, DONE.
- IDLE: on start==1 -> LATCH, dbg_addr<=0, busy<=1. start is ignored in every other state.
- LATCH: dbg_data is stable, because dbg_addr was set on the previous edge.
  - Captures dbg_data into the shift register.
  - Loads tx_data with bits [DATA_WIDTH-1:DATA_WIDTH-8] and sets tx_valid<=1.
  - byte_cnt<=0; next state SEND.
- SEND: a byte transfers on a cycle with tx_valid&&tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data must hold stable.
  - On a transfer with byte_cnt<DATA_WIDTH/8-1: shift left 8, load the next byte (MSB first), keep tx_valid=1, byte_cnt++. Back-to-back bytes are possible, one per cycle.
  - On the transfer of the last byte: tx_valid<=0, next state NEXT.
- NEXT:
  - If dbg_addr==NUM_REGS-1 -> DONE.
  - Else dbg_addr<=dbg_addr+1 -> LATCH.
  - dbg_addr never wraps during a dump.
- DONE: done<=1 for exactly one cycle, busy<=0, dbg_addr<=0 -> IDLE.
- Latency with tx_ready held at 1: start edge to first tx_valid = 2 cycles; per register = 1 LATCH + DATA_WIDTH/8 SEND + 1 NEXT cycles.
- Byte order: register 0 first; within a register, MSB byte first.
- start held high through DONE: a new dump begins only once IDLE is re-entered and start is sampled high again, i.e. one idle cycle between dumps.
- Register 0 is dumped as whatever dbg_data returns; no special-casing.

Optional Feature:
- Macro: REG_DUMP_FRAME_EN.
- Enabled: adds states HDR and CSUM.
  - IDLE+start -> HDR, which sends byte 8'hA5 before register 0.
  - NEXT at the last register -> CSUM, which sends the XOR of all data bytes (the header is excluded), then -> DONE.
  - Frame length = NUM_REGS*DATA_WIDTH/8 + 2 bytes (130 for the defaults).
  - The checksum accumulator clears on start.
- Disabled: raw stream of NUM_REGS*DATA_WIDTH/8 bytes (128), with no header or checksum logic.

Decomposition:
- Package reg_dump_pkg:
  - state enum (IDLE, LATCH, SEND, NEXT, DONE, HDR, CSUM).
  - FRAME_HEADER=8'hA5.
  - BYTES_PER_REG=DATA_WIDTH/8 and the byte counter width.
- Sub-module word_byte_serializer: loads a word, presents bytes MSB-first on a valid/ready interface and flags the last byte. The top-level FSM handles address sequencing, framing and done/busy.

Test Plan:
- Register model holds reg[i]=32'h0101_0101*i; pulse start with tx_ready=1 -> 128 bytes 00 00 00 00, 01 01 01 01, ..., 1F 1F 1F 1F in order; done pulses once; busy low afterwards.
- Same model with tx_ready toggling 1/0 at random -> identical byte sequence; tx_data stable on every stalled cycle; no dropped or duplicated bytes.
- reg[5]=32'hDEADBEEF; start -> bytes 20..23 are DE AD BE EF.
- Pull reset low while tx_valid=1 at register 3 -> next cycle tx_valid=0, busy=0, dbg_addr=0; a subsequent start restarts from register 0.
- Pulse start again while busy -> ignored; exactly 128 bytes and one done pulse.
- With REG_DUMP_FRAME_EN and reg[1]=32'h000000FF, all others 0 -> 130 bytes: A5, 128 data bytes, checksum FF.
